risc_ctrl_fsm: RTL

- Parametrised multicycle control FSM for the Simple RISC Machine datapath.
- Sequences fetch, decode, ALU, MOV, LDR/STR and the full branch set: B, BEQ, BNE, BLT, BLE, BL, BX, BLX.
- Resolves conditional branches from the status flags Z/N/V and inserts a configurable number of memory wait states.
- Supports halt with optional resume and a sticky illegal-instruction flag.

---
 rtl/risc_ctrl_fsm.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multicycle control FSM for the Simple RISC Machine datapath.
// Sequences instruction fetch (with MEM_WAIT memory wait states), decode, ALU,
// MOV, LDR/STR, the branch set B/BEQ/BNE/BLT/BLE/BL/BX/BLX, and HALT.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   opcode/op/cond           IR[15:13], IR[12:11], IR[10:8] (held in IR after IF2)
//   Z, N, V                  status flags for conditional branches
//   run                      resume request, only looked at in HALT
//   loada..loads, load_*     datapath / IR / PC / address register loads
//   asel, bsel, addr_sel     datapath muxes (addr_sel=1 selects PC)
//   reset_pc, pc_sel         PC control (00 PC+1, 01 PC+sximm8, 10 C)
//   mem_cmd                  00 none, 11 read, 01 write
//   vsel, nsel, write        register-file write source, register select, write enable
//   w, err, state_dbg        waiting indicator, sticky illegal flag, state code
module risc_ctrl_fsm #(
  parameter int MEM_WAIT    = 1,
  parameter int HALT_RESUME = 0,
  parameter int LINK_REG    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       run,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_addr,
  output logic       asel,
  output logic       bsel,
  output logic       addr_sel,
  output logic       reset_pc,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic [1:0] vsel,
  output logic [2:0] nsel,
  output logic       write,
  output logic       w,
  output logic       err,
  output logic [5:0] state_dbg
);

  typedef enum logic [5:0] {
    S_RESET = 6'd0,  S_IF1 = 6'd1,     S_WAIT_F = 6'd2,  S_IF2 = 6'd3,
    S_UPDATE_PC = 6'd4, S_DECODE = 6'd5, S_MOV_IMM = 6'd6, S_GET_A = 6'd7,
    S_GET_B = 6'd8,  S_EXEC = 6'd9,    S_WB = 6'd10,     S_CMP = 6'd11,
    S_ADDR = 6'd12,  S_ADDR_C = 6'd13, S_ADDR_LD = 6'd14, S_RD = 6'd15,
    S_WAIT_D = 6'd16, S_LD_WB = 6'd17, S_ST_B = 6'd18,   S_ST_C = 6'd19,
    S_ST_W = 6'd20,  S_BR_PC = 6'd21,  S_LINK = 6'd22,   S_BX_B = 6'd23,
    S_BX_C = 6'd24,  S_BX_PC = 6'd25,  S_HALT = 6'd26
  } state_t;

  localparam logic [3:0] WAIT_INIT = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);
  localparam logic [1:0] MC_READ   = 2'b11;
  localparam logic [1:0] MC_WRITE  = 2'b01;

  state_t     state, next;
  logic [3:0] wcnt;
  logic       cnt_load, cnt_dec, err_set, taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      err   <= 1'b0;
      wcnt  <= 4'd0;
    end else begin
      state <= next;
      if (err_set) err <= 1'b1;
      if (cnt_load)     wcnt <= WAIT_INIT;
      else if (cnt_dec) wcnt <= wcnt - 4'd1;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Z;
      3'b010:  taken = !Z;
      3'b011:  taken = N ^ V;
      3'b100:  taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next      = S_RESET;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    err_set   = 1'b0;
    loada     = 1'b0;  loadb = 1'b0;  loadc = 1'b0;  loads = 1'b0;
    load_ir   = 1'b0;  load_pc = 1'b0;  load_addr = 1'b0;
    asel      = 1'b0;  bsel = 1'b0;  addr_sel = 1'b0;  reset_pc = 1'b0;
    pc_sel    = 2'b00; mem_cmd = 2'b00; vsel = 2'b00; nsel = 3'b000;
    write     = 1'b0;  w = 1'b0;
    case (state)
      S_RESET: begin
        reset_pc = 1'b1; load_pc = 1'b1; w = 1'b1;
        next = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1; mem_cmd = MC_READ;
        if (MEM_WAIT == 0) next = S_IF2;
        else begin next = S_WAIT_F; cnt_load = 1'b1; end
      end
      S_WAIT_F: begin
        addr_sel = 1'b1; mem_cmd = MC_READ;
        if (wcnt == 4'd0) next = S_IF2;
        else begin next = S_WAIT_F; cnt_dec = 1'b1; end
      end
      S_IF2: begin
        addr_sel = 1'b1; mem_cmd = MC_READ; load_ir = 1'b1;
        next = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        next = S_DECODE;
      end
      S_DECODE: begin
        next = S_HALT;
        err_set = 1'b1;
        case (opcode)
          3'b110: begin err_set = 1'b0; next = (op == 2'b10) ? S_MOV_IMM : S_GET_B; end
          3'b101: begin err_set = 1'b0; next = (op == 2'b11) ? S_GET_B : S_GET_A; end
          3'b011, 3'b100: if (op == 2'b00) begin err_set = 1'b0; next = S_ADDR; end
          3'b001: if (op == 2'b00) begin err_set = 1'b0; next = taken ? S_BR_PC : S_IF1; end
          3'b010: if (op != 2'b01) begin
            err_set = 1'b0;
            next = (op == 2'b00) ? S_BX_B : S_LINK;
          end
          3'b111: err_set = 1'b0;
          default: ;
        endcase
      end
      S_MOV_IMM: begin nsel = 3'b100; vsel = 2'b10; write = 1'b1; next = S_IF1; end
      S_GET_A:   begin nsel = 3'b100; loada = 1'b1; next = S_GET_B; end
      S_GET_B: begin
        nsel = 3'b001; loadb = 1'b1;
        next = (opcode == 3'b101 && op == 2'b01) ? S_CMP : S_EXEC;
      end
      // Register MOV passes B through the ALU with A forced to zero.
      S_EXEC:    begin asel = (opcode == 3'b110); loadc = 1'b1; next = S_WB; end
      S_WB:      begin nsel = 3'b010; write = 1'b1; next = S_IF1; end
      S_CMP:     begin loads = 1'b1; next = S_IF1; end
      S_ADDR:    begin nsel = 3'b100; loada = 1'b1; next = S_ADDR_C; end
      S_ADDR_C:  begin bsel = 1'b1; loadc = 1'b1; next = S_ADDR_LD; end
      S_ADDR_LD: begin load_addr = 1'b1; next = (opcode == 3'b011) ? S_RD : S_ST_B; end
      S_RD: begin
        mem_cmd = MC_READ;
        if (MEM_WAIT == 0) next = S_LD_WB;
        else begin next = S_WAIT_D; cnt_load = 1'b1; end
      end
      S_WAIT_D: begin
        mem_cmd = MC_READ;
        if (wcnt == 4'd0) next = S_LD_WB;
        else begin next = S_WAIT_D; cnt_dec = 1'b1; end
      end
      // Read command stays asserted so mdata is still valid during the write.
      S_LD_WB: begin
        mem_cmd = MC_READ; nsel = 3'b010; vsel = 2'b11; write = 1'b1;
        next = S_IF1;
      end
      S_ST_B:  begin nsel = 3'b010; loadb = 1'b1; next = S_ST_C; end
      S_ST_C:  begin asel = 1'b1; loadc = 1'b1; next = S_ST_W; end
      S_ST_W:  begin mem_cmd = MC_WRITE; next = S_IF1; end
      S_BR_PC: begin load_pc = 1'b1; pc_sel = 2'b01; next = S_IF1; end
      // PC already points at the next instruction after UPDATE_PC.
      S_LINK: begin
        nsel = 3'(LINK_REG); vsel = 2'b01; write = 1'b1;
        next = (op == 2'b11) ? S_BR_PC : S_BX_B;
      end
      S_BX_B:  begin nsel = 3'b010; loadb = 1'b1; next = S_BX_C; end
      S_BX_C:  begin asel = 1'b1; loadc = 1'b1; next = S_BX_PC; end
      S_BX_PC: begin load_pc = 1'b1; pc_sel = 2'b10; next = S_IF1; end
      S_HALT: begin
        w = 1'b1;
        next = (HALT_RESUME != 0 && run) ? S_IF1 : S_HALT;
      end
      default: next = S_RESET;
    endcase
  end

  assign state_dbg = state;

endmodule
